// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU front-end sequencer.
package alu_pkg;

  localparam int DATA_IN_W = 10;
  localparam int RESULT_W  = 16;
  localparam int FLAGS_W   = 5;

  localparam logic LD_ACTIVE = 1'b0;
  localparam logic LD_IDLE   = 1'b1;

  typedef enum logic [2:0] {
    S_OP   = 3'd0,
    S_SRC  = 3'd1,
    S_DEST = 3'd2,
    S_WAIT = 3'd3,
    S_SHOW = 3'd4
  } seq_state_t;

  // LED phase code: WAIT and SHOW share phase 3.
  function automatic logic [1:0] step_of(input seq_state_t s);
    logic [1:0] r;
    case (s)
      S_OP:    r = 2'd0;
      S_SRC:   r = 2'd1;
      S_DEST:  r = 2'd2;
      S_WAIT:  r = 2'd3;
      S_SHOW:  r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton synchronizer, debouncer and press detector (active-low button).
// After reset the detector is disarmed until the button has been seen released
// for DEBOUNCE_CYCLES samples, so a button held through reset gives no event.
module btn_debounce
  import alu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press_evt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Synchronizer resets to the "pressed" level so only real samples can arm.
  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_evt_q, press_evt_d;

  // Debounce counter, arming and stable-level tracking.
  always_comb begin
    stable_d    = stable_q;
    armed_d     = armed_q;
    cnt_d       = cnt_q;
    press_evt_d = 1'b0;
    if (!armed_q) begin
      if (sync2_q == 1'b1) begin
        if (cnt_q == CNT_LAST) begin
          armed_d = 1'b1;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_d = {CNT_W{1'b0}};
      end
    end else if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d    = sync2_q;
        cnt_d       = {CNT_W{1'b0}};
        press_evt_d = stable_q & ~sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      stable_q    <= 1'b1;
      armed_q     <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      press_evt_q <= 1'b0;
    end else begin
      sync1_q     <= btn_n;
      sync2_q     <= sync1_q;
      stable_q    <= stable_d;
      armed_q     <= armed_d;
      cnt_q       <= cnt_d;
      press_evt_q <= press_evt_d;
    end
  end

  assign press_evt = press_evt_q;

endmodule

// File: rtl/alu_input_sequencer.sv
// Turns button presses into the ALU wrapper op/src/dest load protocol and
// captures the wrapper result a fixed delay after the destination load.
module alu_input_sequencer
  import alu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CAPTURE_DELAY   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 btn_n,
  input  logic [DATA_IN_W-1:0] switches,
  output logic [DATA_IN_W-1:0] data_input,
  output logic                 ld_op_code,
  output logic                 ld_src,
  output logic                 ld_dest,
  input  logic [RESULT_W-1:0]  Out,
  input  logic [FLAGS_W-1:0]   Flags,
  output logic [RESULT_W-1:0]  result_q,
  output logic [FLAGS_W-1:0]   flags_q,
  output logic                 result_valid,
  output logic [1:0]           step
);

  localparam logic [3:0] WAIT_LOAD = 4'(CAPTURE_DELAY - 1);

  logic press_evt;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_n     (btn_n),
    .press_evt (press_evt)
  );

  seq_state_t           state_q, state_d;
  logic [DATA_IN_W-1:0] data_q, data_d;
  logic                 ld_op_q, ld_op_d, ld_src_q, ld_src_d, ld_dest_q, ld_dest_d;
  logic [3:0]           wait_q, wait_d;
  logic [RESULT_W-1:0]  res_q, res_d;
  logic [FLAGS_W-1:0]   flg_q, flg_d;
  logic                 valid_q, valid_d;
  logic [1:0]           step_q, step_d;

  // Next-state, load strobes and capture logic; strobes default idle so each lasts one cycle.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    ld_op_d   = LD_IDLE;
    ld_src_d  = LD_IDLE;
    ld_dest_d = LD_IDLE;
    wait_d    = wait_q;
    res_d     = res_q;
    flg_d     = flg_q;
    valid_d   = valid_q;
    case (state_q)
      S_OP: begin
        if (press_evt) begin
          data_d  = switches;
          ld_op_d = LD_ACTIVE;
          state_d = S_SRC;
        end else begin
          state_d = S_OP;
        end
      end
      S_SRC: begin
        if (press_evt) begin
          data_d   = switches;
          ld_src_d = LD_ACTIVE;
          state_d  = S_DEST;
        end else begin
          state_d = S_SRC;
        end
      end
      S_DEST: begin
        if (press_evt) begin
          data_d    = switches;
          ld_dest_d = LD_ACTIVE;
          wait_d    = WAIT_LOAD;
          state_d   = S_WAIT;
        end else begin
          state_d = S_DEST;
        end
      end
      S_WAIT: begin
        // Presses arriving here are intentionally dropped.
        if (wait_q == 4'd0) begin
          res_d   = Out;
          flg_d   = Flags;
          valid_d = 1'b1;
          state_d = S_SHOW;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_SHOW: begin
        if (press_evt) begin
          valid_d = 1'b0;
          state_d = S_OP;
        end else begin
          state_d = S_SHOW;
        end
      end
      default: begin
        state_d = S_OP;
        valid_d = 1'b0;
      end
    endcase
    step_d = step_of(state_d);
  end

  // Registered state and outputs; reset forces strobes idle on the next edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_OP;
      data_q    <= {DATA_IN_W{1'b0}};
      ld_op_q   <= LD_IDLE;
      ld_src_q  <= LD_IDLE;
      ld_dest_q <= LD_IDLE;
      wait_q    <= 4'd0;
      res_q     <= {RESULT_W{1'b0}};
      flg_q     <= {FLAGS_W{1'b0}};
      valid_q   <= 1'b0;
      step_q    <= 2'd0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      ld_op_q   <= ld_op_d;
      ld_src_q  <= ld_src_d;
      ld_dest_q <= ld_dest_d;
      wait_q    <= wait_d;
      res_q     <= res_d;
      flg_q     <= flg_d;
      valid_q   <= valid_d;
      step_q    <= step_d;
    end
  end

  assign data_input   = data_q;
  assign ld_op_code   = ld_op_q;
  assign ld_src       = ld_src_q;
  assign ld_dest      = ld_dest_q;
  assign result_q     = res_q;
  assign flags_q      = flg_q;
  assign result_valid = valid_q;
  assign step         = step_q;

endmodule
